// File: rtl/cpu_sdr_responder.sv
// cpu_sdr_responder: turns CPU ROM/RAM bus cycles into SDRAM CPU-port requests.
// A single 64-bit line buffer serves sequential reads without new SDRAM
// accesses; writes go straight through and update the buffer when it holds
// the written line. Writes to read-only regions are acknowledged and dropped.
module cpu_sdr_responder #(
    parameter int SDR_AW = 25
) (
    input  logic              clk_sys,
    input  logic              reset_n,
    input  logic              bus_rd,
    input  logic              bus_wr,
    input  logic [1:0]        bus_be,
    input  logic [15:0]       bus_din,
    output logic [15:0]       bus_dout,
    output logic              ready,
    input  logic              ram_rom_memrq,
    input  logic              writable,
    input  logic [SDR_AW-1:0] sdr_addr,
    input  logic              flush,
    output logic              sdr_req,
    output logic              sdr_we,
    output logic [SDR_AW-1:0] sdr_a,
    output logic [1:0]        sdr_be,
    output logic [15:0]       sdr_wdata,
    input  logic [63:0]       sdr_rdata,
    input  logic              sdr_ack
);

    localparam int TAG_W = SDR_AW - 3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_WAIT,
        ST_WR_WAIT,
        ST_DONE,
        ST_RELEASE
    } state_t;

    state_t            state_q, state_d;
    logic [63:0]       line_q, line_d;
    logic [TAG_W-1:0]  tag_q, tag_d;
    logic              valid_q, valid_d;
    logic              flush_seen_q, flush_seen_d;
    logic [1:0]        wsel_q, wsel_d;
    logic [15:0]       dout_q, dout_d;
    logic              req_q, req_d;
    logic              we_q, we_d;
    logic [SDR_AW-1:0] a_q, a_d;
    logic [1:0]        be_q, be_d;
    logic [15:0]       wdata_q, wdata_d;
    logic              hit;

    // Pick halfword idx out of a little-endian 64-bit line.
    function automatic logic [15:0] sel_half(input logic [63:0] l, input logic [1:0] idx);
        return l[int'(idx)*16 +: 16];
    endfunction

    // Merge the enabled bytes of a written halfword into the line.
    function automatic logic [63:0] merge_half(input logic [63:0] l, input logic [1:0] idx,
                                               input logic [1:0] be, input logic [15:0] d);
        logic [63:0] r;
        r = l;
        if (be[0]) r[int'(idx)*16 +: 8]     = d[7:0];
        if (be[1]) r[int'(idx)*16 + 8 +: 8] = d[15:8];
        return r;
    endfunction

    // A flush in the same cycle as a read must not be served from stale data.
    assign hit = valid_q && (tag_q == sdr_addr[SDR_AW-1:3]) && !flush;

    // Next-state, buffer and request computation.
    always_comb begin
        state_d      = state_q;
        line_d       = line_q;
        tag_d        = tag_q;
        valid_d      = valid_q;
        flush_seen_d = flush_seen_q;
        wsel_d       = wsel_q;
        dout_d       = dout_q;
        req_d        = req_q;
        we_d         = we_q;
        a_d          = a_q;
        be_d         = be_q;
        wdata_d      = wdata_q;

        case (state_q)
            ST_IDLE: begin
                if (ram_rom_memrq) begin
                    if (bus_wr) begin
                        if (writable) begin
                            we_d    = 1'b1;
                            a_d     = sdr_addr;
                            be_d    = bus_be;
                            wdata_d = bus_din;
                            req_d   = 1'b1;
                            state_d = ST_WR_WAIT;
                        end else begin
                            state_d = ST_DONE;
                        end
                    end else if (bus_rd) begin
                        if (hit) begin
                            dout_d  = sel_half(line_q, sdr_addr[2:1]);
                            state_d = ST_DONE;
                        end else begin
                            we_d         = 1'b0;
                            a_d          = {sdr_addr[SDR_AW-1:3], 3'b000};
                            wsel_d       = sdr_addr[2:1];
                            flush_seen_d = flush;
                            req_d        = 1'b1;
                            state_d      = ST_RD_WAIT;
                        end
                    end
                end
            end
            ST_RD_WAIT: begin
                flush_seen_d = flush_seen_q | flush;
                if (sdr_ack) begin
                    req_d   = 1'b0;
                    line_d  = sdr_rdata;
                    tag_d   = a_q[SDR_AW-1:3];
                    valid_d = !(flush_seen_q | flush);
                    dout_d  = sel_half(sdr_rdata, wsel_q);
                    state_d = ST_DONE;
                end
            end
            ST_WR_WAIT: begin
                if (sdr_ack) begin
                    req_d = 1'b0;
                    if (valid_q && (tag_q == a_q[SDR_AW-1:3])) begin
                        line_d = merge_half(line_q, a_q[2:1], be_q, wdata_q);
                    end
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_RELEASE;
            end
            ST_RELEASE: begin
                if (!bus_rd && !bus_wr) state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (flush) valid_d = 1'b0;
    end

    // Control state and request/response registers, cleared by reset.
    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            valid_q <= 1'b0;
            req_q   <= 1'b0;
            dout_q  <= '0;
            we_q    <= 1'b0;
            a_q     <= '0;
            be_q    <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            req_q   <= req_d;
            dout_q  <= dout_d;
            we_q    <= we_d;
            a_q     <= a_d;
            be_q    <= be_d;
            wdata_q <= wdata_d;
        end
    end

    // Line contents and per-request bookkeeping; meaningless until valid is set.
    always_ff @(posedge clk_sys) begin
        line_q       <= line_d;
        tag_q        <= tag_d;
        flush_seen_q <= flush_seen_d;
        wsel_q       <= wsel_d;
    end

    assign ready     = (state_q == ST_DONE);
    assign bus_dout  = dout_q;
    assign sdr_req   = req_q;
    assign sdr_we    = we_q;
    assign sdr_a     = a_q;
    assign sdr_be    = be_q;
    assign sdr_wdata = wdata_q;

endmodule

// File: tb/tb_cpu_sdr_responder.sv
// Bench for cpu_sdr_responder: expected read data is queued per access and
// compared when ready pulses; request timing is checked cycle by cycle.
module tb_cpu_sdr_responder;

    localparam int AW = 25;

    logic          clk_sys = 1'b0;
    logic          reset_n;
    logic          bus_rd, bus_wr;
    logic [1:0]    bus_be;
    logic [15:0]   bus_din;
    logic [15:0]   bus_dout;
    logic          ready;
    logic          ram_rom_memrq, writable;
    logic [AW-1:0] sdr_addr;
    logic          flush;
    logic          sdr_req, sdr_we;
    logic [AW-1:0] sdr_a;
    logic [1:0]    sdr_be;
    logic [15:0]   sdr_wdata;
    logic [63:0]   sdr_rdata;
    logic          sdr_ack;

    int            n_vec = 0;
    int            n_err = 0;
    int            n_ready = 0;
    int            ready_before;
    logic [16:0]   exp_q[$];   // bit16 = don't-care data (writes)
    logic [16:0]   mon_e;

    always #5 clk_sys = ~clk_sys;

    cpu_sdr_responder #(.SDR_AW(AW)) dut (
        .clk_sys      (clk_sys),
        .reset_n      (reset_n),
        .bus_rd       (bus_rd),
        .bus_wr       (bus_wr),
        .bus_be       (bus_be),
        .bus_din      (bus_din),
        .bus_dout     (bus_dout),
        .ready        (ready),
        .ram_rom_memrq(ram_rom_memrq),
        .writable     (writable),
        .sdr_addr     (sdr_addr),
        .flush        (flush),
        .sdr_req      (sdr_req),
        .sdr_we       (sdr_we),
        .sdr_a        (sdr_a),
        .sdr_be       (sdr_be),
        .sdr_wdata    (sdr_wdata),
        .sdr_rdata    (sdr_rdata),
        .sdr_ack      (sdr_ack)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every ready pulse must match the oldest queued access.
    always @(negedge clk_sys) begin
        if (ready === 1'b1) begin
            n_ready++;
            if (exp_q.size() == 0) begin
                chk("ready_unexpected", 64'd1, 64'd0);
            end else begin
                mon_e = exp_q.pop_front();
                if (!mon_e[16]) chk("bus_dout", 64'(bus_dout), 64'(mon_e[15:0]));
            end
        end
    end

    // fl: 0 none, 1 flush with the strobe, 2 flush during the SDRAM wait.
    task automatic rd(input logic [AW-1:0] addr, input bit miss, input logic [63:0] rdata,
                      input int dly, input logic [15:0] exp, input int fl, input int hold);
        @(negedge clk_sys);
        sdr_addr      = addr;
        ram_rom_memrq = 1'b1;
        bus_rd        = 1'b1;
        flush         = (fl == 1);
        exp_q.push_back({1'b0, exp});
        @(negedge clk_sys);
        flush = 1'b0;
        if (miss) begin
            chk("rd_req", 64'(sdr_req), 64'd1);
            chk("rd_we", 64'(sdr_we), 64'd0);
            chk("rd_a", 64'(sdr_a), 64'({addr[AW-1:3], 3'b000}));
            for (int i = 0; i < dly; i++) begin
                if (fl == 2 && i == 1) flush = 1'b1;
                @(negedge clk_sys);
                flush = 1'b0;
                chk("rd_req_held", 64'(sdr_req), 64'd1);
            end
            chk("rd_noready_at_ack", 64'(ready), 64'd0);
            sdr_ack   = 1'b1;
            sdr_rdata = rdata;
            @(negedge clk_sys);
            sdr_ack   = 1'b0;
            sdr_rdata = 64'h0;
            chk("rd_ready", 64'(ready), 64'd1);
            chk("rd_req_drop", 64'(sdr_req), 64'd0);
        end else begin
            chk("hit_ready", 64'(ready), 64'd1);
            chk("hit_noreq", 64'(sdr_req), 64'd0);
        end
        repeat (hold) @(negedge clk_sys);
        bus_rd = 1'b0;
        repeat (2) @(negedge clk_sys);
    endtask

    task automatic wr(input logic [AW-1:0] addr, input logic [15:0] data, input logic [1:0] be,
                      input bit wrt, input int dly);
        @(negedge clk_sys);
        sdr_addr      = addr;
        ram_rom_memrq = 1'b1;
        bus_wr        = 1'b1;
        bus_din       = data;
        bus_be        = be;
        writable      = wrt;
        exp_q.push_back({1'b1, 16'h0});
        @(negedge clk_sys);
        if (wrt) begin
            chk("wr_req", 64'(sdr_req), 64'd1);
            chk("wr_we", 64'(sdr_we), 64'd1);
            chk("wr_a", 64'(sdr_a), 64'(addr));
            chk("wr_be", 64'(sdr_be), 64'(be));
            chk("wr_wdata", 64'(sdr_wdata), 64'(data));
            repeat (dly) @(negedge clk_sys);
            sdr_ack = 1'b1;
            @(negedge clk_sys);
            sdr_ack = 1'b0;
            chk("wr_ready", 64'(ready), 64'd1);
            chk("wr_req_drop", 64'(sdr_req), 64'd0);
        end else begin
            chk("drop_ready", 64'(ready), 64'd1);
            chk("drop_noreq", 64'(sdr_req), 64'd0);
        end
        bus_wr   = 1'b0;
        writable = 1'b0;
        @(negedge clk_sys);
        chk("wr_req_after", 64'(sdr_req), 64'd0);
        @(negedge clk_sys);
    endtask

    initial begin
        reset_n       = 1'b0;
        bus_rd        = 1'b0;
        bus_wr        = 1'b0;
        bus_be        = 2'b00;
        bus_din       = 16'h0;
        ram_rom_memrq = 1'b0;
        writable      = 1'b0;
        sdr_addr      = '0;
        flush         = 1'b0;
        sdr_rdata     = 64'h0;
        sdr_ack       = 1'b0;
        repeat (3) @(negedge clk_sys);
        chk("rst_ready", 64'(ready), 64'd0);
        chk("rst_req", 64'(sdr_req), 64'd0);
        chk("rst_dout", 64'(bus_dout), 64'd0);
        chk("rst_a", 64'(sdr_a), 64'd0);
        chk("rst_we", 64'(sdr_we), 64'd0);
        reset_n = 1'b1;
        @(negedge clk_sys);

        // Miss fills the line, then sequential hits.
        rd(25'h0100008, 1'b1, 64'h4444_3333_2222_1111, 4, 16'h1111, 0, 0);
        rd(25'h010000A, 1'b0, 64'h0, 0, 16'h2222, 0, 0);
        rd(25'h010000E, 1'b0, 64'h0, 0, 16'h4444, 0, 0);

        // Write-through with upper-byte merge into the buffered line.
        wr(25'h010000C, 16'hABCD, 2'b10, 1'b1, 2);
        rd(25'h010000C, 1'b0, 64'h0, 0, 16'hAB33, 0, 0);

        // Dropped write leaves the buffer alone.
        wr(25'h010000A, 16'h5555, 2'b11, 1'b0, 0);
        rd(25'h010000A, 1'b0, 64'h0, 0, 16'h2222, 0, 0);

        // Flush during the wait: data returned, line not kept.
        rd(25'h0200004, 1'b1, 64'hDDDD_CCCC_BBBB_AAAA, 3, 16'hCCCC, 2, 0);
        rd(25'h0200004, 1'b1, 64'h8888_7777_6666_5555, 2, 16'h7777, 0, 0);
        rd(25'h0200006, 1'b0, 64'h0, 0, 16'h8888, 0, 0);

        // Flush coinciding with a read that would otherwise hit.
        rd(25'h0200000, 1'b1, 64'h0004_0003_0002_0001, 1, 16'h0001, 1, 0);

        // Reset while a write is outstanding; a late ack must be ignored.
        @(negedge clk_sys);
        sdr_addr      = 25'h0300000;
        ram_rom_memrq = 1'b1;
        bus_wr        = 1'b1;
        bus_din       = 16'h1234;
        bus_be        = 2'b11;
        writable      = 1'b1;
        @(negedge clk_sys);
        chk("rstw_req", 64'(sdr_req), 64'd1);
        reset_n = 1'b0;
        bus_wr  = 1'b0;
        @(negedge clk_sys);
        chk("rstw_req_drop", 64'(sdr_req), 64'd0);
        chk("rstw_noready", 64'(ready), 64'd0);
        reset_n = 1'b1;
        sdr_ack = 1'b1;
        @(negedge clk_sys);
        sdr_ack = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_sys);
            chk("rstw_late_ack", 64'({ready, sdr_req}), 64'd0);
        end
        writable = 1'b0;

        // Strobe held past DONE yields a single ready pulse.
        ready_before = n_ready;
        rd(25'h0300002, 1'b1, 64'h0D0D_0C0C_0B0B_0A0A, 2, 16'h0B0B, 0, 6);
        chk("hold_one_ready", 64'(n_ready - ready_before), 64'd1);

        chk("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
